// File: rtl/rv_ssc_bundle_issue.sv
`default_nettype none
// ============================================================================
// Module   : rv_ssc_bundle_issue
// Brief    : Issue-side bundler. Queues flagged instruction words and forms
//            1/2/3-wide issue bundles in a registered output stage.
//            Optional bundle-width counters under RVSSC_BUNDLE_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rv_ssc_bundle_issue #(
    parameter int QDEPTH   = 8,
    parameter int PC_W     = 48,
    parameter bit EN_3WIDE = 1'b1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_count,
    input  logic [95:0]         in_word,
    input  logic [11:0]         in_flag,
    input  logic [3*PC_W-1:0]   in_pc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_count,
    output logic [95:0]         out_word,
    output logic [PC_W-1:0]     out_pc,
    output logic [95:0]         stat_cnt
);

    localparam int c_PTR_W = $clog2(QDEPTH);
    localparam int c_OCC_W = c_PTR_W + 1;

    logic [31:0]        r_qWord [QDEPTH];
    logic [3:0]         r_qFlag [QDEPTH];
    logic [PC_W-1:0]    r_qPc   [QDEPTH];
    logic [c_PTR_W-1:0] r_rdPtr;
    logic [c_PTR_W-1:0] r_wrPtr;
    logic [c_OCC_W-1:0] r_occ;

    logic               r_outValid;
    logic [1:0]         r_outCount;
    logic [95:0]        r_outWord;
    logic [PC_W-1:0]    r_outPc;

    logic               w_push;
    logic [1:0]         w_pushN;
    logic               w_canLoad;
    logic               w_load;
    logic [1:0]         w_selN;
    logic [1:0]         w_popN;
    logic [c_PTR_W-1:0] w_idx1;
    logic [c_PTR_W-1:0] w_idx2;
    logic [31:0]        w_e0, w_e1, w_e2;
    logic [3:0]         w_f0, w_f1, w_f2;
    logic               w_sel3;
    logic               w_sel2;
    logic [95:0]        w_bundleWord;

    // Writer's destination clobbers any source or destination of the later word.
    function automatic logic hz(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] rdA;
        rdA = a[11:7];
        return (rdA != 5'd0) && ((rdA == b[19:15]) || (rdA == b[24:20]) || (rdA == b[11:7]));
    endfunction

    assign in_ready  = (c_OCC_W'(QDEPTH) - r_occ) >= c_OCC_W'(3);
    assign w_push    = in_valid && in_ready && !flush && (in_count != 2'd0);
    assign w_pushN   = w_push ? in_count : 2'd0;
    assign w_canLoad = !r_outValid || out_ready;
    assign w_load    = w_canLoad && (r_occ != '0) && !flush;

    assign w_idx1 = r_rdPtr + c_PTR_W'(1);
    assign w_idx2 = r_rdPtr + c_PTR_W'(2);
    assign w_e0   = r_qWord[r_rdPtr];
    assign w_e1   = r_qWord[w_idx1];
    assign w_e2   = r_qWord[w_idx2];
    assign w_f0   = r_qFlag[r_rdPtr];
    assign w_f1   = r_qFlag[w_idx1];
    assign w_f2   = r_qFlag[w_idx2];

    assign w_sel3 = EN_3WIDE && (r_occ >= c_OCC_W'(3)) && w_f0[1] && w_f1[2] && w_f2[3] &&
                    !hz(w_e0, w_e1) && !hz(w_e0, w_e2) && !hz(w_e1, w_e2);
    assign w_sel2 = (r_occ >= c_OCC_W'(2)) && w_f0[0] && w_f1[2] && !hz(w_e0, w_e1);
    assign w_selN = w_sel3 ? 2'd3 : (w_sel2 ? 2'd2 : 2'd1);
    assign w_popN = w_load ? w_selN : 2'd0;

    always_comb begin
        w_bundleWord        = '0;
        w_bundleWord[31:0]  = w_e0;
        if (w_selN != 2'd1) begin
            w_bundleWord[63:32] = w_e1;
        end
        if (w_selN == 2'd3) begin
            w_bundleWord[95:64] = w_e2;
        end
    end

    // Storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (w_push && (2'(k) < in_count)) begin
                r_qWord[r_wrPtr + c_PTR_W'(k)] <= in_word[32*k +: 32];
                r_qFlag[r_wrPtr + c_PTR_W'(k)] <= in_flag[4*k +: 4];
                r_qPc[r_wrPtr + c_PTR_W'(k)]   <= in_pc[PC_W*k +: PC_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_occ   <= '0;
        end else if (flush) begin
            r_rdPtr <= r_wrPtr;
            r_occ   <= '0;
        end else begin
            r_wrPtr <= r_wrPtr + c_PTR_W'(w_pushN);
            r_rdPtr <= r_rdPtr + c_PTR_W'(w_popN);
            r_occ   <= r_occ + c_OCC_W'(w_pushN) - c_OCC_W'(w_popN);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_outValid <= 1'b0;
            r_outCount <= 2'd0;
            r_outWord  <= '0;
            r_outPc    <= '0;
        end else if (flush || (w_canLoad && !w_load)) begin
            r_outValid <= 1'b0;
            r_outCount <= 2'd0;
            r_outWord  <= '0;
            r_outPc    <= '0;
        end else if (w_load) begin
            r_outValid <= 1'b1;
            r_outCount <= w_selN;
            r_outWord  <= w_bundleWord;
            r_outPc    <= r_qPc[r_rdPtr];
        end
    end

    assign out_valid = r_outValid;
    assign out_count = r_outCount;
    assign out_word  = r_outWord;
    assign out_pc    = r_outPc;

`ifdef RVSSC_BUNDLE_STATS_EN
    logic [31:0] r_statSingle;
    logic [31:0] r_statDual;
    logic [31:0] r_statTriple;
    logic        w_handshake;

    assign w_handshake = r_outValid && out_ready;

    // Saturating; flush deliberately leaves the history intact.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_statSingle <= '0;
            r_statDual   <= '0;
            r_statTriple <= '0;
        end else if (w_handshake) begin
            if ((r_outCount == 2'd1) && (r_statSingle != '1)) r_statSingle <= r_statSingle + 32'd1;
            if ((r_outCount == 2'd2) && (r_statDual   != '1)) r_statDual   <= r_statDual   + 32'd1;
            if ((r_outCount == 2'd3) && (r_statTriple != '1)) r_statTriple <= r_statTriple + 32'd1;
        end
    end

    assign stat_cnt = {r_statTriple, r_statDual, r_statSingle};
`else
    assign stat_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rv_ssc_bundle_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_ssc_bundle_issue
// Brief    : Directed vector table, hand sequences and randomized run against a
//            queue-based reference model of the bundler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_ssc_bundle_issue;

    localparam int QDEPTH = 8;
    localparam int PC_W   = 48;

    localparam logic [31:0] c_A  = 32'h00100093;  // addi x1,x0,1
    localparam logic [31:0] c_B  = 32'h00200113;  // addi x2,x0,2
    localparam logic [31:0] c_C  = 32'h006283B3;  // add, rd=x7 rs1=x5 rs2=x6
    localparam logic [31:0] c_D  = 32'h002081B3;  // add x3,x1,x2
    localparam logic [31:0] c_LW = 32'h00032283;  // lw x5,0(x6)
    localparam logic [31:0] c_BR = 32'h00000063;  // beq x0,x0,0
    localparam logic [95:0] c_Z  = 96'd0;

    logic              clk;
    logic              rstN;
    logic              flush;
    logic              inValid;
    logic [1:0]        inCount;
    logic [95:0]       inWord;
    logic [11:0]       inFlag;
    logic [3*PC_W-1:0] inPc;
    logic              outReady;
    logic              inReady, outValid;
    logic [1:0]        outCount;
    logic [95:0]       outWord;
    logic [PC_W-1:0]   outPc;
    logic [95:0]       statCnt;
    logic              inReady1, outValid1;
    logic [1:0]        outCount1;
    logic [95:0]       outWord1;
    logic [PC_W-1:0]   outPc1;
    logic [95:0]       statCnt1;

    rv_ssc_bundle_issue #(.QDEPTH(QDEPTH), .PC_W(PC_W), .EN_3WIDE(1'b1)) dut (
        .clock(clk), .reset(rstN), .flush(flush), .in_valid(inValid), .in_ready(inReady),
        .in_count(inCount), .in_word(inWord), .in_flag(inFlag), .in_pc(inPc),
        .out_valid(outValid), .out_ready(outReady), .out_count(outCount),
        .out_word(outWord), .out_pc(outPc), .stat_cnt(statCnt));

    rv_ssc_bundle_issue #(.QDEPTH(QDEPTH), .PC_W(PC_W), .EN_3WIDE(1'b0)) dutNo3 (
        .clock(clk), .reset(rstN), .flush(flush), .in_valid(inValid), .in_ready(inReady1),
        .in_count(inCount), .in_word(inWord), .in_flag(inFlag), .in_pc(inPc),
        .out_valid(outValid1), .out_ready(outReady), .out_count(outCount1),
        .out_word(outWord1), .out_pc(outPc1), .stat_cnt(statCnt1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nChk = 0;
    int nErr = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChk++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0]     w;
        logic [3:0]      f;
        logic [PC_W-1:0] pc;
    } ent_t;

    ent_t            mq[$];
    logic            mV;
    logic [1:0]      mCnt;
    logic [95:0]     mWord;
    logic [PC_W-1:0] mPc;
    logic [31:0]     mStat[3];

    function automatic logic hzM(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] d;
        d = a[11:7];
        return (d != 5'd0) && (d == b[19:15] || d == b[24:20] || d == b[11:7]);
    endfunction

    function automatic int selWidth();
        int n;
        n = mq.size();
        if (n >= 3 && mq[0].f[1] && mq[1].f[2] && mq[2].f[3] &&
            !hzM(mq[0].w, mq[1].w) && !hzM(mq[0].w, mq[2].w) && !hzM(mq[1].w, mq[2].w))
            return 3;
        if (n >= 2 && mq[0].f[0] && mq[1].f[2] && !hzM(mq[0].w, mq[1].w))
            return 2;
        return 1;
    endfunction

    task automatic modelClearOut();
        mV = 1'b0; mCnt = 2'd0; mWord = '0; mPc = '0;
    endtask

    task automatic modelReset();
        mq.delete();
        modelClearOut();
        for (int k = 0; k < 3; k++) mStat[k] = '0;
    endtask

    task automatic modelStep();
        int   n;
        logic acc;
        ent_t e;
        if (mV && outReady && mStat[mCnt-1] != 32'hFFFF_FFFF) mStat[mCnt-1] = mStat[mCnt-1] + 1;
        if (flush) begin
            mq.delete();
            modelClearOut();
        end else begin
            acc = inValid && ((QDEPTH - mq.size()) >= 3);
            if (!mV || outReady) begin
                if (mq.size() > 0) begin
                    n = selWidth();
                    mV = 1'b1; mCnt = 2'(n); mWord = '0; mPc = mq[0].pc;
                    for (int k = 0; k < n; k++) mWord[32*k +: 32] = mq[k].w;
                    for (int k = 0; k < n; k++) void'(mq.pop_front());
                end else begin
                    modelClearOut();
                end
            end
            if (acc) begin
                for (int k = 0; k < int'(inCount); k++) begin
                    e.w = inWord[32*k +: 32]; e.f = inFlag[4*k +: 4]; e.pc = inPc[PC_W*k +: PC_W];
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic chkModel(input string p);
        logic [95:0] es;
`ifdef RVSSC_BUNDLE_STATS_EN
        es = {mStat[2], mStat[1], mStat[0]};
`else
        es = '0;
`endif
        chk({p, "_valid"}, 128'(outValid), 128'(mV));
        chk({p, "_count"}, 128'(outCount), 128'(mCnt));
        chk({p, "_word"},  128'(outWord),  128'(mWord));
        chk({p, "_pc"},    128'(outPc),    128'(mPc));
        chk({p, "_stat"},  128'(statCnt),  128'(es));
        chk({p, "_ready"}, 128'(inReady),  128'((QDEPTH - mq.size()) >= 3));
    endtask

    // ---------------- stimulus helpers ----------------
    logic [PC_W-1:0] pcCnt = 48'h1000;

    task automatic drive(input logic fl, input logic iv, input logic [1:0] cnt,
                         input logic [95:0] w, input logic [11:0] f, input logic orr);
        flush = fl; inValid = iv; inCount = cnt; inWord = w; inFlag = f; outReady = orr;
        inPc = {pcCnt + 48'd8, pcCnt + 48'd4, pcCnt};
        pcCnt = pcCnt + 48'd12;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstN) modelStep();
        #1;
    endtask

    typedef struct {
        logic        iv;
        logic [1:0]  cnt;
        logic [95:0] w;
        logic [11:0] f;
        logic        expV;
        logic [1:0]  expC;
        logic [95:0] expW;
        logic        chk1;
        logic [1:0]  e1C;
        logic [95:0] e1W;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [1:0] cnt, input logic [95:0] w,
                                input logic [11:0] f, input logic expV, input logic [1:0] expC,
                                input logic [95:0] expW, input logic chk1, input logic [1:0] e1C,
                                input logic [95:0] e1W);
        vec_t v;
        v.iv = iv; v.cnt = cnt; v.w = w; v.f = f; v.expV = expV; v.expC = expC; v.expW = expW;
        v.chk1 = chk1; v.e1C = e1C; v.e1W = e1W;
        return v;
    endfunction

    vec_t        tbl[16];
    logic [31:0] seqW[9];
    logic [95:0] rw;
    logic [11:0] rf;
    logic [31:0] tmp;
    logic [95:0] expStat;
    int          idx;

    initial begin
        // row inputs are applied before an edge, expectations sampled just after it
        tbl[0]  = mk(1'b1, 2'd3, {c_C, c_B, c_A},  12'hFFF, 1'b0, 2'd0, c_Z, 1'b1, 2'd0, c_Z);
        tbl[1]  = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b1, 2'd3, {c_C, c_B, c_A}, 1'b1, 2'd2, {32'd0, c_B, c_A});
        tbl[2]  = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b0, 2'd0, c_Z, 1'b1, 2'd1, {64'd0, c_C});
        tbl[3]  = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b0, 2'd0, c_Z, 1'b1, 2'd0, c_Z);
        tbl[4]  = mk(1'b1, 2'd3, {c_D, c_B, c_A},  12'hFFF, 1'b0, 2'd0, c_Z, 1'b0, 2'd0, c_Z);
        tbl[5]  = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b1, 2'd2, {32'd0, c_B, c_A}, 1'b0, 2'd0, c_Z);
        tbl[6]  = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b1, 2'd1, {64'd0, c_D}, 1'b0, 2'd0, c_Z);
        tbl[7]  = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b0, 2'd0, c_Z, 1'b0, 2'd0, c_Z);
        tbl[8]  = mk(1'b1, 2'd2, {32'd0, c_A, c_LW},  12'h0F3, 1'b0, 2'd0, c_Z, 1'b0, 2'd0, c_Z);
        tbl[9]  = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b1, 2'd2, {32'd0, c_A, c_LW}, 1'b0, 2'd0, c_Z);
        tbl[10] = mk(1'b1, 2'd2, {32'd0, c_BR, c_LW}, 12'h003, 1'b0, 2'd0, c_Z, 1'b0, 2'd0, c_Z);
        tbl[11] = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b1, 2'd1, {64'd0, c_LW}, 1'b0, 2'd0, c_Z);
        tbl[12] = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b1, 2'd1, {64'd0, c_BR}, 1'b0, 2'd0, c_Z);
        tbl[13] = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b0, 2'd0, c_Z, 1'b0, 2'd0, c_Z);
        tbl[14] = mk(1'b1, 2'd0, {c_C, c_B, c_A}, 12'hFFF, 1'b0, 2'd0, c_Z, 1'b0, 2'd0, c_Z);
        tbl[15] = mk(1'b0, 2'd0, c_Z, 12'h000, 1'b0, 2'd0, c_Z, 1'b0, 2'd0, c_Z);

        rstN = 1'b0;
        drive(1'b0, 1'b0, 2'd0, c_Z, 12'h000, 1'b0);
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 128'(outValid), 128'(0));
        chk("rst_count", 128'(outCount), 128'(0));
        chk("rst_word",  128'(outWord),  128'(0));
        chk("rst_pc",    128'(outPc),    128'(0));
        chk("rst_stat",  128'(statCnt),  128'(0));
        rstN = 1'b1;
        chk("rst_ready", 128'(inReady),  128'(1));

        for (int i = 0; i < 16; i++) begin
            drive(1'b0, tbl[i].iv, tbl[i].cnt, tbl[i].w, tbl[i].f, 1'b1);
            tick();
            chk($sformatf("vec%0d_valid", i), 128'(outValid), 128'(tbl[i].expV));
            chk($sformatf("vec%0d_count", i), 128'(outCount), 128'(tbl[i].expC));
            chk($sformatf("vec%0d_word", i),  128'(outWord),  128'(tbl[i].expW));
            chk($sformatf("vec%0d_ready", i), 128'(inReady),  128'(1));
            if (tbl[i].chk1) begin
                chk($sformatf("vec%0d_no3_valid", i), 128'(outValid1), 128'(tbl[i].e1C != 2'd0));
                chk($sformatf("vec%0d_no3_count", i), 128'(outCount1), 128'(tbl[i].e1C));
                chk($sformatf("vec%0d_no3_word", i),  128'(outWord1),  128'(tbl[i].e1W));
            end
            if (i == 7) begin
`ifdef RVSSC_BUNDLE_STATS_EN
                expStat = {32'd1, 32'd1, 32'd1};
`else
                expStat = '0;
`endif
                chk("stat_after_s1s2", 128'(statCnt), 128'(expStat));
            end
        end

        // stall with a full queue, then drain in order across the pointer wrap
        for (int k = 0; k < 9; k++) seqW[k] = 32'hA000_0000 + 32'(k << 12);
        drive(1'b0, 1'b1, 2'd3, {seqW[2], seqW[1], seqW[0]}, 12'h000, 1'b0);
        tick();
        chk("full_g1_valid", 128'(outValid), 128'(0));
        drive(1'b0, 1'b1, 2'd3, {seqW[5], seqW[4], seqW[3]}, 12'h000, 1'b0);
        tick();
        chk("full_g2_word",  128'(outWord),  128'({64'd0, seqW[0]}));
        chk("full_g2_ready", 128'(inReady),  128'(1));
        drive(1'b0, 1'b1, 2'd3, {seqW[8], seqW[7], seqW[6]}, 12'h000, 1'b0);
        tick();
        chk("full_g3_ready", 128'(inReady),  128'(0));
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 2'd3, {3{32'hDEAD_BEEF}}, 12'hFFF, 1'b0);
            tick();
            chk("full_hold_valid", 128'(outValid), 128'(1));
            chk("full_hold_count", 128'(outCount), 128'(1));
            chk("full_hold_word",  128'(outWord),  128'({64'd0, seqW[0]}));
            chk("full_hold_ready", 128'(inReady),  128'(0));
        end
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (outValid) begin
                chk("drain_word", 128'(outWord), 128'({64'd0, (idx < 9) ? seqW[idx % 9] : 32'hFFFF_FFFF}));
                idx++;
            end
            drive(1'b0, 1'b0, 2'd0, c_Z, 12'h000, 1'b1);
            tick();
        end
        chk("drain_total", 128'(idx), 128'(9));

        // flush with a held bundle and five queued entries
        drive(1'b0, 1'b1, 2'd3, {3{32'h1111_0000}}, 12'h000, 1'b0);
        tick();
        drive(1'b0, 1'b1, 2'd3, {3{32'h2222_0000}}, 12'h000, 1'b0);
        tick();
        chk("flush_pre_valid", 128'(outValid), 128'(1));
        drive(1'b1, 1'b1, 2'd3, {3{32'h3333_0000}}, 12'h000, 1'b0);
        tick();
        chk("flush_valid", 128'(outValid), 128'(0));
        chk("flush_count", 128'(outCount), 128'(0));
        chk("flush_word",  128'(outWord),  128'(0));
        chk("flush_ready", 128'(inReady),  128'(1));
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 2'd0, c_Z, 12'h000, 1'b1);
            tick();
            chk("flush_after_valid", 128'(outValid), 128'(0));
        end

        // randomized traffic, narrow register fields to provoke hazards
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++) begin
                tmp = $urandom;
                tmp[11:7]  = 5'($urandom_range(0, 3));
                tmp[19:15] = 5'($urandom_range(0, 3));
                tmp[24:20] = 5'($urandom_range(0, 3));
                rw[32*k +: 32] = tmp;
                rf[4*k +: 4]   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            end
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 6, 2'($urandom_range(0, 3)),
                  rw, rf, $urandom_range(0, 9) < 7);
            tick();
            chkModel("rnd");
        end

        // asynchronous reset between clock edges
        drive(1'b0, 1'b1, 2'd3, {3{32'h4444_0000}}, 12'h000, 1'b0);
        tick();
        drive(1'b0, 1'b0, 2'd0, c_Z, 12'h000, 1'b0);
        tick();
        chk("arst_pre_valid", 128'(outValid), 128'(1));
        #3;
        rstN = 1'b0;
        #1;
        chk("arst_valid", 128'(outValid), 128'(0));
        chk("arst_count", 128'(outCount), 128'(0));
        chk("arst_word",  128'(outWord),  128'(0));
        chk("arst_pc",    128'(outPc),    128'(0));
        chk("arst_stat",  128'(statCnt),  128'(0));
        chk("arst_ready", 128'(inReady),  128'(1));
        modelReset();
        @(posedge clk);
        #1;
        rstN = 1'b1;
        drive(1'b0, 1'b1, 2'd3, {c_C, c_B, c_A}, 12'hFFF, 1'b1);
        tick();
        drive(1'b0, 1'b0, 2'd0, c_Z, 12'h000, 1'b1);
        tick();
        chkModel("post_arst");

        $display("Result: errors=%0d of %0d checks", nErr, nChk);
        $finish;
    end

endmodule
`default_nettype wire
